// File: rtl/axb_eval.sv
// Sequential y = a*x + b evaluator: WIDTH-cycle shift-add multiply, one add cycle, one done cycle.
// The phase output is the raw state encoding and feeds the downstream phase decoder/select stage.
module axb_eval #(
  parameter int unsigned WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic [WIDTH-1:0]     a_i,
  input  logic [WIDTH-1:0]     x_i,
  input  logic [WIDTH-1:0]     b_i,
  output logic [1:0]           phase_o,
  output logic                 busy_o,
  output logic                 done_o,
  output logic [2*WIDTH:0]     y_o
);

  localparam int unsigned PW = 2 * WIDTH;
  localparam int unsigned YW = 2 * WIDTH + 1;
  localparam int unsigned CW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_ADD  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [PW-1:0]   acc_q, acc_d;
  logic [PW-1:0]   mcand_q, mcand_d;
  logic [WIDTH-1:0] mplier_q, mplier_d;
  logic [WIDTH-1:0] b_r_q, b_r_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [YW-1:0]   y_q, y_d;

  // State and datapath registers; reset overrides everything including start.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      b_r_q    <= '0;
      cnt_q    <= '0;
      y_q      <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      b_r_q    <= b_r_d;
      cnt_q    <= cnt_d;
      y_q      <= y_d;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_d  = state_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    b_r_d    = b_r_q;
    cnt_d    = cnt_q;
    y_d      = y_q;
    case (state_q)
      S_IDLE: begin
        if (start_i) begin
          mcand_d  = PW'(a_i);
          mplier_d = x_i;
          b_r_d    = b_i;
          acc_d    = '0;
          cnt_d    = '0;
          state_d  = S_MUL;
        end
      end
      S_MUL: begin
        // Fixed WIDTH iterations regardless of operand values.
        if (mplier_q[0]) begin
          acc_d = acc_q + mcand_q;
        end
        mcand_d  = mcand_q << 1;
        mplier_d = mplier_q >> 1;
        cnt_d    = cnt_q + CW'(1);
        if (cnt_q == CW'(WIDTH - 1)) begin
          state_d = S_ADD;
        end
      end
      S_ADD: begin
        y_d     = YW'(acc_q) + YW'(b_r_q);
        state_d = S_DONE;
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  assign phase_o = 2'(state_q);
  assign busy_o  = (state_q == S_MUL) || (state_q == S_ADD);
  assign done_o  = (state_q == S_DONE);
  assign y_o     = y_q;

endmodule

// File: tb/tb_axb_eval.sv
// Directed bench for axb_eval (WIDTH=8): phase/busy/done timing, results, ignored start,
// held start, mid-multiply reset and idle behaviour.
module tb_axb_eval;

  localparam int unsigned W = 8;

  logic           clk;
  logic           rst_n;
  logic           start;
  logic [W-1:0]   a, x, b;
  logic [1:0]     phase;
  logic           busy;
  logic           done;
  logic [2*W:0]   y;

  int n_checks;
  int n_fail;

  axb_eval #(.WIDTH(W)) dut (
    .clk     (clk),
    .rst_n   (rst_n),
    .start_i (start),
    .a_i     (a),
    .x_i     (x),
    .b_i     (b),
    .phase_o (phase),
    .busy_o  (busy),
    .done_o  (done),
    .y_o     (y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic idle_checks(input int cycles, input logic [31:0] ey, input string tag);
    for (int i = 0; i < cycles; i++) begin
      chk({tag, "_phase"}, 32'(phase), 32'd0);
      chk({tag, "_busy"}, 32'(busy), 32'd0);
      chk({tag, "_done"}, 32'(done), 32'd0);
      chk({tag, "_y"}, 32'(y), ey);
      step();
    end
  endtask

  // One evaluation from accept edge through the return to IDLE. pulse_k >= 0 drives an
  // extra start (a=x=b=1) in that cycle; hold keeps start high throughout.
  task automatic run_eval(input logic [W-1:0] ia, input logic [W-1:0] ix, input logic [W-1:0] ib,
                          input logic [31:0] ey, input int pulse_k, input bit hold, input string tag);
    int exp_ph;
    a = ia; x = ix; b = ib; start = 1'b1;
    step();
    start = hold;
    if (!hold) begin
      a = W'($urandom); x = W'($urandom); b = W'($urandom);
    end
    for (int k = 0; k <= int'(W) + 2; k++) begin
      exp_ph = (k < int'(W)) ? 1 : (k == int'(W)) ? 2 : (k == int'(W) + 1) ? 3 : 0;
      chk({tag, "_phase"}, 32'(phase), 32'(exp_ph));
      chk({tag, "_busy"}, 32'(busy), 32'((exp_ph == 1) || (exp_ph == 2)));
      chk({tag, "_done"}, 32'(done), 32'(exp_ph == 3));
      if (k >= int'(W) + 1) chk({tag, "_y"}, 32'(y), ey);
      if (k == pulse_k) begin
        start = 1'b1; a = 1; x = 1; b = 1;
      end else begin
        start = hold;
      end
      if (k < int'(W) + 2) step();
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst_n = 1'b0; start = 1'b0; a = '0; x = '0; b = '0;
    step();
    step();
    rst_n = 1'b1;

    // Idle after reset.
    idle_checks(20, 32'd0, "idle20");

    run_eval(8'd3,   8'd5,   8'd7,   32'd22,    -1, 1'b0, "e3x5p7");
    run_eval(8'd255, 8'd255, 8'd255, 32'd65280, -1, 1'b0, "max");
    run_eval(8'd0,   8'd200, 8'd9,   32'd9,     -1, 1'b0, "a0");
    run_eval(8'd1,   8'd0,   8'd0,   32'd0,     -1, 1'b0, "x0");

    // Start pulsed in MUL cycle 4 must be ignored.
    run_eval(8'd3, 8'd5, 8'd7, 32'd22, 4, 1'b0, "ign");
    start = 1'b0;
    idle_checks(12, 32'd22, "ign_after");

    // Start held high: back-to-back every W+3 cycles.
    for (int r = 0; r < 3; r++) begin
      run_eval(8'd2, 8'd3, 8'd4, 32'd10, -1, 1'b1, "hold");
    end
    start = 1'b0;
    step();

    // Reset during MUL cycle 5.
    a = 8'd9; x = 8'd9; b = 8'd9; start = 1'b1;
    step();
    start = 1'b0;
    for (int k = 0; k < 5; k++) begin
      chk("rst_pre_phase", 32'(phase), 32'd1);
      step();
    end
    chk("rst_pre_phase5", 32'(phase), 32'd1);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    idle_checks(12, 32'd0, "rst_after");
    run_eval(8'd6, 8'd7, 8'd1, 32'd43, -1, 1'b0, "post_rst");

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
